uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched_if.sv | 19 +
 rtl/uart_tx_sched.sv | 142 ++++++++++++++
 tb/tb_uart_tx_sched.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
// Requester-side handshake bundle for uart_tx_sched: two valid/data/ready channels.
interface uart_tx_sched_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin scheduler feeding a single 8N1 UART transmitter.
// One byte is accepted per IDLE cycle; tx/busy/owner are registered from next-state values.
module uart_tx_sched #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_sched_if.slave  req,
  output logic            tx,
  output logic            busy,
  output logic            owner
);

  localparam int unsigned TIMER_W = 16;
  localparam int unsigned BIT_W   = 3;
  localparam logic [TIMER_W-1:0] BIT_LAST = TIMER_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [BIT_W-1:0]   bit_q,   bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               last_q,  last_d;
  logic               owner_q, owner_d;
  logic               tx_q,    tx_d;
  logic               busy_q,  busy_d;
  logic               grant0_c, grant1_c;
  logic               ready0_c, ready1_c;
  logic               bit_done_c;

  // Round-robin: on contention the requester not granted last time wins; no grant under reset.
  always_comb begin
    grant1_c = !reset && req.req1_valid && (!req.req0_valid || !last_q);
    grant0_c = !reset && req.req0_valid && !grant1_c;
  end

  assign bit_done_c = (timer_q == BIT_LAST);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    last_d   = last_q;
    owner_d  = owner_q;
    ready0_c = 1'b0;
    ready1_c = 1'b0;
    tx_d     = 1'b1;
    busy_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant0_c || grant1_c) begin
          ready0_c = grant0_c;
          ready1_c = grant1_c;
          shift_d  = grant1_c ? req.req1_data : req.req0_data;
          owner_d  = grant1_c;
          last_d   = grant1_c;
          timer_d  = '0;
          bit_d    = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bit_done_c) begin
          timer_d = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_DATA: begin
        if (bit_done_c) begin
          timer_d = '0;
          if (bit_q == BIT_W'(7)) begin
            bit_d   = '0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_STOP: begin
        if (bit_done_c) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
        bit_d   = '0;
      end
    endcase

    // Line level is derived from the upcoming state so tx drops the cycle after acceptance.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[bit_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign req.req0_ready = ready0_c;
  assign req.req1_ready = ready1_c;
  assign tx             = tx_q;
  assign busy           = busy_q;
  assign owner          = owner_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched at CLKS_PER_BIT=4: vector table of single frames plus corner sequences.
module tb_uart_tx_sched;

  localparam int unsigned CPB = 4;

  logic clk;
  logic reset;
  logic tx;
  logic busy;
  logic owner;
  int   checks;
  int   failures;

  uart_tx_sched_if bus ();

  uart_tx_sched #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (bus),
    .tx    (tx),
    .busy  (busy),
    .owner (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       exp_owner;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reset with both valids high: nothing may be granted while reset is asserted.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("reset_ready_comb", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk("reset_state", {27'd0, tx, busy, owner, bus.req1_ready, bus.req0_ready}, 32'b10000);
    reset = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!(bus.req0_ready || bus.req1_ready) && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'd1, 32'd0);
  endtask

  // Walks the 40 frame cycles after an acceptance cycle; mode selects stimulus pokes mid-frame.
  task automatic check_frame(input logic [7:0] exp_byte, input logic exp_owner,
                             input string name, input int mode);
    int         errs;
    logic [7:0] got;
    logic       exp_tx;
    errs = 0;
    got  = 8'h00;
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge clk);
      if (k == 0 && mode != 0) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      if (mode == 2 && k == 10 * CPB - 1) begin
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'hC3;
      end
      if (mode == 3) begin
        if (k == 5)  bus.req0_data = ~bus.req0_data;
        if (k == 10) begin bus.req1_valid = 1'b1; bus.req1_data = 8'hEE; end
        if (k == 12) bus.req1_valid = 1'b0;
        if (k == 20) bus.req0_data = 8'h00;
      end
      #1;
      if (k < CPB)            exp_tx = 1'b0;
      else if (k < 9 * CPB)   exp_tx = exp_byte[(k - CPB) / CPB];
      else                    exp_tx = 1'b1;
      if (tx !== exp_tx || busy !== 1'b1 || bus.req0_ready || bus.req1_ready) errs++;
      if (k >= CPB && k < 9 * CPB && ((k - CPB) % CPB) == CPB / 2)
        got[(k - CPB) / CPB] = tx;
    end
    chk({"frame_", name}, errs, 0);
    chk({"byte_", name}, {24'd0, got}, {24'd0, exp_byte});
    chk({"owner_", name}, {31'd0, owner}, {31'd0, exp_owner});
  endtask

  task automatic check_quiet(input string name, input int cycles);
    int act;
    act = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      #1;
      if (busy || !tx || bus.req0_ready || bus.req1_ready) act++;
    end
    chk(name, act, 0);
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req0_data  = 8'h00;
    bus.req1_valid = 1'b0;
    bus.req1_data  = 8'h00;

    vecs[0] = '{v0: 1'b1, d0: 8'hA5, v1: 1'b0, d1: 8'h00, exp_owner: 1'b0, exp_byte: 8'hA5};
    vecs[1] = '{v0: 1'b0, d0: 8'h00, v1: 1'b1, d1: 8'hFF, exp_owner: 1'b1, exp_byte: 8'hFF};
    vecs[2] = '{v0: 1'b1, d0: 8'h11, v1: 1'b1, d1: 8'h22, exp_owner: 1'b0, exp_byte: 8'h11};
    vecs[3] = '{v0: 1'b1, d0: 8'h00, v1: 1'b0, d1: 8'h99, exp_owner: 1'b0, exp_byte: 8'h00};
    vecs[4] = '{v0: 1'b0, d0: 8'h42, v1: 1'b1, d1: 8'h3C, exp_owner: 1'b1, exp_byte: 8'h3C};

    repeat (2) @(negedge clk);

    // Single frames from a fresh reset each time.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      bus.req0_valid = vecs[i].v0;
      bus.req0_data  = vecs[i].d0;
      bus.req1_valid = vecs[i].v1;
      bus.req1_data  = vecs[i].d1;
      #1;
      wait_ready(n);
      chk("vec_ready", {30'd0, bus.req1_ready, bus.req0_ready},
          vecs[i].exp_owner ? 32'b10 : 32'b01);
      check_frame(vecs[i].exp_byte, vecs[i].exp_owner, "vec", 1);
      @(negedge clk);
      #1;
      chk("vec_idle", {28'd0, tx, busy, bus.req1_ready, bus.req0_ready}, 32'b1000);
    end

    // Continuous contention: grants alternate 0,1,0,1 with a single idle cycle between frames.
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_data = 8'h11;
    bus.req1_valid = 1'b1; bus.req1_data = 8'h22;
    #1;
    wait_ready(n);
    chk("rr_first_wait", n, 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
        chk("rr_gap_line", {30'd0, tx, busy}, 32'b10);
      end
      chk("rr_ready", {30'd0, bus.req1_ready, bus.req0_ready}, (i % 2) ? 32'b10 : 32'b01);
      check_frame((i % 2) ? 8'h22 : 8'h11, 1'((i % 2)), "rr", 0);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check_quiet("rr_tail_quiet", 3);

    // Reset in frame cycle 15 of a 0x00 frame aborts it; req0 wins the first contention afterwards.
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_data = 8'h00;
    #1;
    wait_ready(n);
    chk("abort_grant", {30'd0, bus.req1_ready, bus.req0_ready}, 32'b01);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) bus.req0_valid = 1'b0;
    end
    #1;
    chk("abort_pre_line", {30'd0, tx, busy}, 32'b01);
    reset = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_data = 8'h5A;
    bus.req1_valid = 1'b1; bus.req1_data = 8'h77;
    #1;
    chk("abort_no_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk("abort_line", {28'd0, tx, busy, bus.req1_ready, bus.req0_ready}, 32'b1000);
    reset = 1'b0;
    #1;
    chk("abort_regrant", {30'd0, bus.req1_ready, bus.req0_ready}, 32'b01);
    check_frame(8'h5A, 1'b0, "after_abort", 1);
    check_quiet("abort_not_resent", 10);

    // req1 raised in the last stop cycle is accepted in the very next idle cycle.
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_data = 8'h96;
    #1;
    wait_ready(n);
    check_frame(8'h96, 1'b0, "stop_edge_a", 2);
    @(negedge clk);
    #1;
    chk("stop_edge_grant", {28'd0, tx, busy, bus.req1_ready, bus.req0_ready}, 32'b1010);
    check_frame(8'hC3, 1'b1, "stop_edge_b", 1);
    check_quiet("stop_edge_quiet", 3);

    // Data edits during a frame are ignored; a req1 pulse dropped before any idle cycle never sends.
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_data = 8'h3C;
    #1;
    wait_ready(n);
    check_frame(8'h3C, 1'b0, "data_change", 3);
    check_quiet("dropped_pulse", 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
